adc_event_packetizer: RTL and testbench

- Downstream of the ADC signal detector; consumes its 16-bit sample stream plus signal_state.
- Captures the samples of each detected event into an internal buffer, then emits a packet on a 32-bit AXI-Stream master: header word followed by packed sample words.
- The stream drives the DMA-side FIFO.
- Single buffer: while a packet drains, new events are dropped and counted.

---
 rtl/adc_event_packetizer_if.sv | 26 ++
 rtl/adc_event_packetizer.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_adc_event_packetizer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc_event_packetizer_if.sv
// AXI-Stream style 32-bit packet bus between the ADC event packetizer
// and the DMA-side FIFO. The master drives data/valid/keep/last and the
// slave returns ready.
interface adc_event_packetizer_if;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  m_keep;
  logic        m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_keep,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_keep,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/adc_event_packetizer.sv
// ADC event packetizer.
// Captures the 16-bit samples of one detected event into a single packed
// buffer, two samples per 32-bit word. The packet is then sent on a 32-bit
// stream: one header word, then the payload words. Events that start while
// a packet is still held are dropped and counted.
// Optional build macro ADC_PACKETIZER_TIMESTAMP_EN adds a free-running cycle
// counter. It is latched on sample 0 and sent as one extra word after the
// header.
module adc_event_packetizer #(
  parameter int MAX_SAMPLES = 256
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [15:0]                   sample_data,
  input  logic                          sample_valid,
  input  logic                          signal_state,
  adc_event_packetizer_if.master        m_axis,
  output logic                          busy,
  output logic [15:0]                   drop_count
);

  localparam int DEPTH = MAX_SAMPLES / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] MAX_CNT = 16'(MAX_SAMPLES);

`ifdef ADC_PACKETIZER_TIMESTAMP_EN
  localparam logic TS_FLAG = 1'b1;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_HEADER  = 3'd2,
    ST_TSTAMP  = 3'd3,
    ST_PAYLOAD = 3'd4
  } state_t;
`else
  localparam logic TS_FLAG = 1'b0;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd4
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        trunc_q, trunc_d;
  logic        armed_q, armed_d;
  logic        prev_q, prev_d;
  logic [7:0]  event_id_q, event_id_d;
  logic [15:0] wptr_q, wptr_d;
  logic [15:0] drop_q, drop_d;
  logic [31:0] m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic [3:0]  m_keep_q, m_keep_d;
  logic        m_last_q, m_last_d;
  logic        busy_q;

  logic [31:0] buf_q [DEPTH];

  logic        wr_en_s;
  logic [15:0] wr_idx_s;
  logic        xfer_s;
  logic [15:0] rd_ptr_s;
  logic [15:0] last_ptr_s;
  logic        rd_last_s;
  logic [31:0] rd_raw_s;
  logic [31:0] rd_data_s;
  logic [3:0]  rd_keep_s;
  logic        in_drain_s;

`ifdef ADC_PACKETIZER_TIMESTAMP_EN
  logic [31:0] ts_cnt_q;
  logic [31:0] ts_q;
  logic        ts_latch_s;
`endif

  // Header layout: event id, truncated flag, timestamp-present flag, sample count.
  function automatic logic [31:0] make_header(input logic [7:0]  id,
                                              input logic        trunc,
                                              input logic [15:0] cnt);
    return {id, trunc, TS_FLAG, 6'b000000, cnt};
  endfunction

  assign m_axis.m_data  = m_data_q;
  assign m_axis.m_valid = m_valid_q;
  assign m_axis.m_keep  = m_keep_q;
  assign m_axis.m_last  = m_last_q;
  assign busy           = busy_q;
  assign drop_count     = drop_q;

  assign xfer_s     = m_valid_q && m_axis.m_ready;
  assign in_drain_s = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD)
`ifdef ADC_PACKETIZER_TIMESTAMP_EN
                      || (state_q == ST_TSTAMP)
`endif
                      ;

  // Fetch the payload word to present after the next handshake, masking the unused half of a final odd word.
  always_comb begin
    rd_ptr_s   = (state_q == ST_PAYLOAD) ? (wptr_q + 16'd1) : 16'd0;
    last_ptr_s = ((count_q + 16'd1) >> 1) - 16'd1;
    rd_last_s  = (rd_ptr_s == last_ptr_s);
    rd_raw_s   = buf_q[rd_ptr_s[AW-1:0]];
    if (rd_last_s && count_q[0]) begin
      rd_data_s = {16'h0000, rd_raw_s[15:0]};
      rd_keep_s = 4'h3;
    end else begin
      rd_data_s = rd_raw_s;
      rd_keep_s = 4'hF;
    end
  end

  // Next-state logic: event capture, drop accounting and stream sequencing.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    trunc_d    = trunc_q;
    armed_d    = armed_q;
    prev_d     = prev_q;
    event_id_d = event_id_q;
    wptr_d     = wptr_q;
    drop_d     = drop_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_keep_d   = m_keep_q;
    m_last_d   = m_last_q;
    wr_en_s    = 1'b0;
    wr_idx_s   = count_q;
`ifdef ADC_PACKETIZER_TIMESTAMP_EN
    ts_latch_s = 1'b0;
`endif

    // Edge tracking, re-arming and drop counting apply in every state.
    if (sample_valid) begin
      prev_d = signal_state;
      if (!signal_state) begin
        armed_d = 1'b1;
      end else if (!prev_q && (in_drain_s || !armed_q)) begin
        drop_d = (drop_q == 16'hFFFF) ? drop_q : (drop_q + 16'd1);
      end else begin
        drop_d = drop_q;
      end
    end else begin
      prev_d = prev_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (sample_valid && signal_state && armed_q) begin
          wr_en_s  = 1'b1;
          wr_idx_s = 16'd0;
          count_d  = 16'd1;
          state_d  = ST_CAPTURE;
`ifdef ADC_PACKETIZER_TIMESTAMP_EN
          ts_latch_s = 1'b1;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CAPTURE: begin
        if (sample_valid && signal_state) begin
          wr_en_s  = 1'b1;
          wr_idx_s = count_q;
          count_d  = count_q + 16'd1;
          if ((count_q + 16'd1) == MAX_CNT) begin
            trunc_d   = 1'b1;
            armed_d   = 1'b0;
            state_d   = ST_HEADER;
            m_valid_d = 1'b1;
            m_data_d  = make_header(event_id_q, 1'b1, count_q + 16'd1);
            m_keep_d  = 4'hF;
            m_last_d  = 1'b0;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else if (sample_valid) begin
          trunc_d   = 1'b0;
          state_d   = ST_HEADER;
          m_valid_d = 1'b1;
          m_data_d  = make_header(event_id_q, 1'b0, count_q);
          m_keep_d  = 4'hF;
          m_last_d  = 1'b0;
        end else begin
          state_d = ST_CAPTURE;
        end
      end

      ST_HEADER: begin
        if (xfer_s) begin
`ifdef ADC_PACKETIZER_TIMESTAMP_EN
          state_d  = ST_TSTAMP;
          m_data_d = ts_q;
          m_keep_d = 4'hF;
          m_last_d = 1'b0;
`else
          state_d  = ST_PAYLOAD;
          wptr_d   = 16'd0;
          m_data_d = rd_data_s;
          m_keep_d = rd_keep_s;
          m_last_d = rd_last_s;
`endif
        end else begin
          state_d = ST_HEADER;
        end
      end

`ifdef ADC_PACKETIZER_TIMESTAMP_EN
      ST_TSTAMP: begin
        if (xfer_s) begin
          state_d  = ST_PAYLOAD;
          wptr_d   = 16'd0;
          m_data_d = rd_data_s;
          m_keep_d = rd_keep_s;
          m_last_d = rd_last_s;
        end else begin
          state_d = ST_TSTAMP;
        end
      end
`endif

      ST_PAYLOAD: begin
        if (xfer_s && m_last_q) begin
          state_d    = ST_IDLE;
          event_id_d = event_id_q + 8'd1;
          m_valid_d  = 1'b0;
          m_data_d   = 32'h0000_0000;
          m_keep_d   = 4'h0;
          m_last_d   = 1'b0;
        end else if (xfer_s) begin
          wptr_d   = wptr_q + 16'd1;
          m_data_d = rd_data_s;
          m_keep_d = rd_keep_s;
          m_last_d = rd_last_s;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any packet in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= 16'd0;
      trunc_q    <= 1'b0;
      armed_q    <= 1'b1;
      prev_q     <= 1'b0;
      event_id_q <= 8'd0;
      wptr_q     <= 16'd0;
      drop_q     <= 16'd0;
      m_data_q   <= 32'h0000_0000;
      m_valid_q  <= 1'b0;
      m_keep_q   <= 4'h0;
      m_last_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      trunc_q    <= trunc_d;
      armed_q    <= armed_d;
      prev_q     <= prev_d;
      event_id_q <= event_id_d;
      wptr_q     <= wptr_d;
      drop_q     <= drop_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_keep_q   <= m_keep_d;
      m_last_q   <= m_last_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  // Sample buffer: even sample index fills the low half-word, odd index the high half-word.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      if (wr_idx_s[0]) begin
        buf_q[wr_idx_s[AW:1]][31:16] <= sample_data;
      end else begin
        buf_q[wr_idx_s[AW:1]][15:0] <= sample_data;
      end
    end
  end

`ifdef ADC_PACKETIZER_TIMESTAMP_EN
  // Free-running cycle counter, latched when sample 0 of an event is stored.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_cnt_q <= 32'd0;
      ts_q     <= 32'd0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (ts_latch_s) begin
        ts_q <= ts_cnt_q;
      end else begin
        ts_q <= ts_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_event_packetizer.sv
// Directed bench for adc_event_packetizer.
// Two instances are used: a default-depth one for the even, odd,
// backpressure, drop and reset scenarios, and a MAX_SAMPLES=4 one for
// truncation. sel_t routes the sample valid to one instance and selects
// which instance's outputs are observed.
module tb_adc_event_packetizer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_data = 16'h0000;
  logic        sample_valid = 1'b0;
  logic        signal_state = 1'b0;
  logic        m_ready = 1'b0;
  logic        sel_t = 1'b0;

  logic        busy_m, busy_t;
  logic [15:0] drop_m, drop_t;

  int checks = 0;
  int errors = 0;

  adc_event_packetizer_if m_if();
  adc_event_packetizer_if t_if();

  assign m_if.m_ready = m_ready;
  assign t_if.m_ready = m_ready;

  adc_event_packetizer #(.MAX_SAMPLES(256)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_data  (sample_data),
    .sample_valid (sample_valid && !sel_t),
    .signal_state (signal_state),
    .m_axis       (m_if),
    .busy         (busy_m),
    .drop_count   (drop_m)
  );

  adc_event_packetizer #(.MAX_SAMPLES(4)) dut_t (
    .clock        (clock),
    .reset        (reset),
    .sample_data  (sample_data),
    .sample_valid (sample_valid && sel_t),
    .signal_state (signal_state),
    .m_axis       (t_if),
    .busy         (busy_t),
    .drop_count   (drop_t)
  );

  logic [31:0] o_data;
  logic        o_valid;
  logic [3:0]  o_keep;
  logic        o_last;
  logic        o_busy;
  logic [15:0] o_drop;

  assign o_data  = sel_t ? t_if.m_data  : m_if.m_data;
  assign o_valid = sel_t ? t_if.m_valid : m_if.m_valid;
  assign o_keep  = sel_t ? t_if.m_keep  : m_if.m_keep;
  assign o_last  = sel_t ? t_if.m_last  : m_if.m_last;
  assign o_busy  = sel_t ? busy_t       : busy_m;
  assign o_drop  = sel_t ? drop_t       : drop_m;

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one sample for one clock edge, return at the following negedge.
  task automatic send(input logic [15:0] d, input logic st);
    sample_data  = d;
    signal_state = st;
    sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
  endtask

  // The word must be offered now with ready high; check it and let it transfer.
  task automatic expect_word(input string tag, input logic [31:0] d,
                             input logic [3:0] k, input logic l);
    chk({tag, "_valid"}, {31'd0, o_valid && m_ready}, 32'd1);
    chk({tag, "_data"}, o_data, d);
    chk({tag, "_keep"}, {28'd0, o_keep}, {28'd0, k});
    chk({tag, "_last"}, {31'd0, o_last}, {31'd0, l});
    @(negedge clock);
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_last", {31'd0, o_last}, 32'd0);
    chk("rst_keep", {28'd0, o_keep}, 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_drop", {16'd0, o_drop}, 32'd0);
    reset = 1'b0;
    m_ready = 1'b1;
    @(negedge clock);

    // Even packet: 4 samples, back-to-back drain
    send(16'h0001, 1'b1);
    chk("even_busy_cap", {31'd0, o_busy}, 32'd1);
    chk("even_novalid_cap", {31'd0, o_valid}, 32'd0);
    send(16'h0002, 1'b1);
    send(16'h0003, 1'b1);
    send(16'h0004, 1'b1);
    send(16'hDEAD, 1'b0);
    expect_word("even_hdr", 32'h0000_0004, 4'hF, 1'b0);
    expect_word("even_w0", 32'h0002_0001, 4'hF, 1'b0);
    expect_word("even_w1", 32'h0004_0003, 4'hF, 1'b1);
    chk("even_done_valid", {31'd0, o_valid}, 32'd0);
    chk("even_done_busy", {31'd0, o_busy}, 32'd0);

    // Odd packet: 3 samples, final word half-filled
    send(16'h000A, 1'b1);
    send(16'h000B, 1'b1);
    send(16'h000C, 1'b1);
    send(16'h0000, 1'b0);
    expect_word("odd_hdr", 32'h0100_0003, 4'hF, 1'b0);
    expect_word("odd_w0", 32'h000B_000A, 4'hF, 1'b0);
    expect_word("odd_w1", 32'h0000_000C, 4'h3, 1'b1);
    chk("odd_done_valid", {31'd0, o_valid}, 32'd0);

    // Backpressure: ready 1 (header), then 0,0,1 on the first payload word
    send(16'h0001, 1'b1);
    send(16'h0002, 1'b1);
    send(16'h0003, 1'b1);
    send(16'h0004, 1'b1);
    send(16'h0000, 1'b0);
    expect_word("bp_hdr", 32'h0200_0004, 4'hF, 1'b0);
    m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp_stall_valid", {31'd0, o_valid}, 32'd1);
      chk("bp_stall_data", o_data, 32'h0002_0001);
      chk("bp_stall_keep", {28'd0, o_keep}, 32'h0000_000F);
      chk("bp_stall_last", {31'd0, o_last}, 32'd0);
      @(negedge clock);
    end
    m_ready = 1'b1;
    expect_word("bp_w0", 32'h0002_0001, 4'hF, 1'b0);
    expect_word("bp_w1", 32'h0004_0003, 4'hF, 1'b1);
    chk("bp_done_valid", {31'd0, o_valid}, 32'd0);

    // Drop: packet held with ready low, two new rising events arrive
    m_ready = 1'b0;
    send(16'h0011, 1'b1);
    send(16'h0022, 1'b1);
    send(16'h0000, 1'b0);
    chk("drop_hdr_held", o_data, 32'h0300_0002);
    send(16'h0055, 1'b1);
    send(16'h0000, 1'b0);
    send(16'h0066, 1'b1);
    send(16'h0067, 1'b1);
    send(16'h0000, 1'b0);
    chk("drop_count2", {16'd0, o_drop}, 32'd2);
    chk("drop_busy", {31'd0, o_busy}, 32'd1);
    chk("drop_valid_held", {31'd0, o_valid}, 32'd1);
    m_ready = 1'b1;
    expect_word("drop_hdr", 32'h0300_0002, 4'hF, 1'b0);
    expect_word("drop_w0", 32'h0022_0011, 4'hF, 1'b1);
    repeat (3) @(negedge clock);
    chk("drop_no_extra", {31'd0, o_valid}, 32'd0);
    chk("drop_count_kept", {16'd0, o_drop}, 32'd2);

    // Reset during payload
    send(16'h0001, 1'b1);
    send(16'h0002, 1'b1);
    send(16'h0003, 1'b1);
    send(16'h0004, 1'b1);
    send(16'h0000, 1'b0);
    expect_word("mid_hdr", 32'h0400_0004, 4'hF, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_drop", {16'd0, o_drop}, 32'd0);
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    send(16'h0005, 1'b1);
    send(16'h0006, 1'b1);
    send(16'h0000, 1'b0);
    expect_word("mid_hdr2", 32'h0000_0002, 4'hF, 1'b0);
    expect_word("mid_w0", 32'h0006_0005, 4'hF, 1'b1);

    // Truncation on the MAX_SAMPLES=4 instance
    sel_t = 1'b1;
    @(negedge clock);
    send(16'h0001, 1'b1);
    send(16'h0002, 1'b1);
    send(16'h0003, 1'b1);
    send(16'h0004, 1'b1);
    sample_data = 16'h0005; signal_state = 1'b1; sample_valid = 1'b1;
    expect_word("tr_hdr", 32'h0080_0004, 4'hF, 1'b0);
    sample_data = 16'h0006;
    expect_word("tr_w0", 32'h0002_0001, 4'hF, 1'b0);
    sample_valid = 1'b0;
    expect_word("tr_w1", 32'h0004_0003, 4'hF, 1'b1);
    chk("tr_drop", {16'd0, o_drop}, 32'd0);
    send(16'h0007, 1'b1);
    send(16'h0007, 1'b1);
    @(negedge clock);
    chk("tr_no_rearm_valid", {31'd0, o_valid}, 32'd0);
    chk("tr_no_rearm_busy", {31'd0, o_busy}, 32'd0);
    chk("tr_drop_still", {16'd0, o_drop}, 32'd0);
    send(16'h0008, 1'b0);
    send(16'h0009, 1'b1);
    send(16'h000A, 1'b1);
    send(16'h0000, 1'b0);
    expect_word("tr_next_hdr", 32'h0100_0002, 4'hF, 1'b0);
    expect_word("tr_next_w0", 32'h000A_0009, 4'hF, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
